// File: rtl/bg_line_fetcher.sv
// bg_line_fetcher: walks the background map and tile data for one scanline and streams 2-bit colour indices
module bg_line_fetcher #(
  parameter int LINE_PIXELS = 160,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        scx,
  input  logic [7:0]        scy,
  input  logic [7:0]        ly,
  input  logic              map_sel,
  input  logic              data_sel,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic [7:0]        vram_rd_data,
  output logic [1:0]        pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, RD_MAP, RD_LO, RD_HI, PUSH} stateT;
  stateT state, nextState;
  logic [7:0] scxR, yR, idxR, loSh, hiSh;
  logic mapSelR, dataSelR, first, doneR;
  logic [4:0] tileX, col;
  logic [8:0] pixCnt;
  logic [3:0] remaining;
  logic [2:0] fine;
  logic [ADDR_W-1:0] mapAddr, tileBase, loAddr, hiAddr;
  logic xfer, lastPix;
  assign xfer = (state == PUSH) && pix_ready;
  assign lastPix = pixCnt == 9'(LINE_PIXELS - 1);
  assign col = scxR[7:3] + tileX;
  assign mapAddr = (mapSelR ? ADDR_W'(32'h1C00) : ADDR_W'(32'h1800)) + ADDR_W'({yR[7:3], col});
  assign tileBase = dataSelR ? (ADDR_W'(idxR) << 4)
                             : ADDR_W'(32'h1000) + ({{(ADDR_W-8){idxR[7]}}, idxR} << 4);
  assign loAddr = tileBase + ADDR_W'({yR[2:0], 1'b0});
  assign hiAddr = loAddr + ADDR_W'(1);
  assign fine = first ? scxR[2:0] : 3'd0;
  assign busy = state != IDLE;
  assign done = doneR;
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nextState;
  // next-state decode and VRAM/pixel outputs
  always_comb begin
    nextState = state;
    vram_addr = '0;
    pix_valid = 1'b0;
    pix_data = 2'd0;
    case (state)
      IDLE: nextState = start ? RD_MAP : IDLE;
      RD_MAP: begin
        vram_addr = mapAddr;
        nextState = RD_LO;
      end
      RD_LO: begin
        vram_addr = loAddr;
        nextState = RD_HI;
      end
      RD_HI: begin
        vram_addr = hiAddr;
        nextState = PUSH;
      end
      PUSH: begin
        pix_valid = 1'b1;
        pix_data = {hiSh[7], loSh[7]};
        if (pix_ready) nextState = lastPix ? IDLE : (remaining == 4'd1) ? RD_MAP : PUSH;
      end
      default: nextState = IDLE;
    endcase
  end
  // latched line parameters, fetched bytes, shifters and counters
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      scxR <= '0;
      yR <= '0;
      idxR <= '0;
      loSh <= '0;
      hiSh <= '0;
      mapSelR <= 1'b0;
      dataSelR <= 1'b0;
      first <= 1'b0;
      doneR <= 1'b0;
      tileX <= '0;
      pixCnt <= '0;
      remaining <= '0;
    end else begin
      doneR <= xfer && lastPix;
      case (state)
        IDLE: if (start) begin
          scxR <= scx;
          yR <= scy + ly;
          mapSelR <= map_sel;
          dataSelR <= data_sel;
          tileX <= '0;
          pixCnt <= '0;
          first <= 1'b1;
        end
        RD_MAP: idxR <= vram_rd_data;
        RD_LO: loSh <= vram_rd_data;
        RD_HI: begin
          hiSh <= vram_rd_data << fine;
          loSh <= loSh << fine;
          remaining <= 4'd8 - {1'b0, fine};
          first <= 1'b0;
        end
        PUSH: if (pix_ready) begin
          hiSh <= hiSh << 1;
          loSh <= loSh << 1;
          pixCnt <= pixCnt + 9'd1;
          remaining <= remaining - 4'd1;
          if (remaining == 4'd1) tileX <= tileX + 5'd1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_bg_line_fetcher.sv
// tb_bg_line_fetcher: scoreboard bench checking streamed pixels against a per-pixel screen model
module tb_bg_line_fetcher;
  logic clk = 0, reset_n = 0, start = 0, map_sel = 0, data_sel = 0, pix_ready = 1;
  logic [7:0] scx = 0, scy = 0, ly = 0;
  logic [12:0] vram_addr;
  logic [7:0] vram_rd_data;
  logic [1:0] pix_data;
  logic pix_valid, busy, done;
  logic [7:0] mem [0:8191];
  logic [1:0] expQ [$];
  logic [12:0] addrs [1:3];
  logic [12:0] mapAddrs [0:2];
  int checks = 0, passes = 0, pixSeen = 0, mapReads = 0, firstValid = 0, doneCyc = 0;
  bit stallMode = 0;
  logic prevStall = 0;
  logic [1:0] prevData = 0;

  bg_line_fetcher #(.LINE_PIXELS(160), .ADDR_W(13)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .scx(scx), .scy(scy), .ly(ly),
    .map_sel(map_sel), .data_sel(data_sel), .vram_addr(vram_addr), .vram_rd_data(vram_rd_data),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready), .busy(busy), .done(done)
  );

  assign vram_rd_data = mem[vram_addr];
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // screen-space model: pixel x of the line is bit (7 - bx%8) of the tile row covering bx = scx + x
  function automatic void model(input int sx, input int sy, input int l, input bit ms, input bit ds);
    int y, bx, idx, s, a, b;
    logic [7:0] lo, hi;
    y = (sy + l) & 255;
    for (int x = 0; x < 160; x++) begin
      bx = (sx + x) & 255;
      idx = mem[(ms ? 'h1C00 : 'h1800) + (y >> 3) * 32 + (bx >> 3)];
      s = ds ? idx * 16 : 'h1000 + (idx >= 128 ? idx - 256 : idx) * 16;
      a = (s + (y & 7) * 2) & 8191;
      lo = mem[a];
      hi = mem[(a + 1) & 8191];
      b = 7 - (bx & 7);
      expQ.push_back({hi[b], lo[b]});
    end
  endfunction

  task automatic randomizeMem();
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
  endtask

  task automatic runLine(input int sx, input int sy, input int l, input bit ms, input bit ds, input bit extra);
    int cyc, tiles, y, expFirst;
    tiles = (160 + (sx & 7) + 7) / 8;
    y = (sy + l) & 255;
    expFirst = (ms ? 'h1C00 : 'h1800) + (y >> 3) * 32 + (sx >> 3);
    pixSeen = 0;
    mapReads = 0;
    firstValid = 0;
    @(posedge clk); #1;
    scx = 8'(sx); scy = 8'(sy); ly = 8'(l); map_sel = ms; data_sel = ds; start = 1;
    model(sx, sy, l, ms, ds);
    @(posedge clk); #1;
    start = 0;
    cyc = 1;
    while (!done && cyc < 5000) begin
      if (cyc <= 3) addrs[cyc] = vram_addr;
      if (vram_addr >= 13'h1800) begin
        if (mapReads < 3) mapAddrs[mapReads] = vram_addr;
        mapReads++;
      end
      if (pix_valid && firstValid == 0) firstValid = cyc;
      if (extra && busy && $urandom_range(0, 7) == 0) begin
        start = 1; scx = 8'($urandom); scy = 8'($urandom); ly = 8'($urandom);
        map_sel = 1'($urandom); data_sel = 1'($urandom);
      end
      @(posedge clk); #1;
      start = 0;
      cyc++;
    end
    doneCyc = cyc;
    chk("done_seen", int'(cyc < 5000), 1);
    chk("busy_low_with_done", busy, 0);
    chk("pixel_count", pixSeen, 160);
    chk("queue_drained", expQ.size(), 0);
    chk("map_reads", mapReads, tiles);
    chk("first_map_addr", mapAddrs[0], expFirst);
    if (!stallMode) chk("done_cycle", doneCyc, 1 + 3 * tiles + 160);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
  endtask

  // ready driver: full-rate or random stalls, changed just after each edge
  initial forever begin
    @(posedge clk); #1;
    pix_ready = stallMode ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // monitor: pops the scoreboard on every transfer and checks no-retraction while stalled
  initial forever begin
    @(negedge clk);
    if (!reset_n) prevStall = 0;
    else begin
      if (prevStall) begin
        chk("stall_valid_held", pix_valid, 1);
        chk("stall_data_held", pix_data, prevData);
      end
      if (pix_valid && pix_ready) begin
        pixSeen++;
        chk("expected_pixel_pending", int'(expQ.size() > 0), 1);
        if (expQ.size() > 0) chk("pixel", pix_data, expQ.pop_front());
      end
      prevStall = pix_valid && !pix_ready;
      prevData = pix_data;
    end
  end

  initial begin
    int n;
    randomizeMem();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vram_addr", vram_addr, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset_n = 1;
    mem[13'h1800] = 8'h01; mem[13'h0010] = 8'hF0; mem[13'h0011] = 8'hAA;
    runLine(0, 0, 0, 0, 1, 0);
    chk("lat_addr_map", addrs[1], 'h1800);
    chk("lat_addr_lo", addrs[2], 'h0010);
    chk("lat_addr_hi", addrs[3], 'h0011);
    chk("first_valid_cycle", firstValid, 4);
    chk("full_line_done_cycle", doneCyc, 221);
    randomizeMem();
    runLine(5, 0, 2, 0, 1, 0);
    mem[13'h1800] = 8'h80;
    runLine(0, 3, 0, 0, 0, 0);
    chk("signed_lo_addr", addrs[2], 'h0806);
    chk("signed_hi_addr", addrs[3], 'h0807);
    runLine(8'hF8, 0, 0, 1, 1, 0);
    chk("wrap_map_first", mapAddrs[0], 'h1C1F);
    chk("wrap_map_second", mapAddrs[1], 'h1C00);
    for (int i = 0; i < 8; i++) begin
      randomizeMem();
      stallMode = i[0];
      runLine(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 153)),
              1'($urandom), 1'($urandom), stallMode);
    end
    stallMode = 1;
    pixSeen = 0;
    @(posedge clk); #1;
    scx = 8'h03; scy = 8'h10; ly = 8'h20; map_sel = 0; data_sel = 1; start = 1;
    model(3, 16, 32, 0, 1);
    @(posedge clk); #1;
    start = 0;
    n = 0;
    while (!(pix_valid && pixSeen >= 5) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reached_push", pix_valid, 1);
    reset_n = 0;
    #1;
    expQ.delete();
    chk("abort_vram_addr", vram_addr, 0);
    chk("abort_pix_valid", pix_valid, 0);
    chk("abort_pix_data", pix_data, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_stays_idle", busy, 0);
    reset_n = 1;
    stallMode = 0;
    runLine(3, 16, 32, 0, 1, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/bg_line_fetcher.md
Name: bg_line_fetcher

Overview:
Reader side of the 8 KiB video RAM: walks the background tile map and tile data for one scanline and streams 2-bit colour indices to the pixel pipeline. It drives a VRAM port whose read data is combinational (same-cycle) and never writes; its write enable is tied low at the top level. One start pulse produces exactly LINE_PIXELS pixels over a valid/ready handshake, honouring SCX/SCY scroll and the LCDC map/data select bits.

Parameters:
LINE_PIXELS, 160, pixels emitted per line (1..256)
ADDR_W, 13, VRAM byte address width (0x0000 = CPU 0x8000)

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a line when idle
scx  in  8  background scroll X, sampled on accepted start
scy  in  8  background scroll Y, sampled on accepted start
ly  in  8  current line number, sampled on accepted start
map_sel  in  1  0: map at 0x1800, 1: map at 0x1C00 (sampled on start)
data_sel  in  1  1: unsigned tiles at 0x0000; 0: signed tiles around 0x1000 (sampled on start)
vram_addr  out  ADDR_W  VRAM read address, combinational from state
vram_rd_data  in  8  VRAM read data, valid same cycle as vram_addr
pix_data  out  2  colour index {hi_bit, lo_bit}
pix_valid  out  1  pix_data valid
pix_ready  in  1  sink accepts pixel
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after last pixel accepted

Behaviour:
- Reset (async assert, sync release): state IDLE; vram_addr=0, pix_data=0, pix_valid=0, busy=0, done=0; all counters and latched inputs 0. Reset mid-line aborts immediately; no further pixels.
- start accepted only in IDLE; ignored while busy. On acceptance latch scx, scy, ly, map_sel, data_sel; tile_x=0, pix_cnt=0, first=1.
- Derived: y = (scy+ly) mod 256; row = y[2:0]; map_addr = base + y[7:3]*32 + ((scx[7:3]+tile_x) & 31), base per map_sel.
- Tile address: data_sel=1 -> idx*16 + row*2; data_sel=0 -> 0x1000 + signed(idx)*16 + row*2 (idx=0x80 -> 0x0800, idx=0x7F -> 0x17F0). Hi byte = lo address + 1. All arithmetic mod 2^ADDR_W.
- States: IDLE -> RD_MAP -> RD_LO -> RD_HI -> PUSH -> (RD_MAP | IDLE).
  RD_MAP: vram_addr=map_addr; capture idx at clock edge.
  RD_LO: vram_addr=lo address; capture lo byte.
  RD_HI: vram_addr=hi address; capture hi byte; load shift registers; remaining = 8, or 8-scx[2:0] if first (shifted left by scx[2:0] so fine-scrolled pixels are never presented); clear first.
  PUSH: pix_valid=1, pix_data={hi[7],lo[7]}; on pix_valid&&pix_ready shift left, pix_cnt++, remaining--. When pix_cnt reaches LINE_PIXELS on a transfer -> IDLE, done=1 next cycle, busy=0 together with done. Else when remaining reaches 0 -> tile_x++, RD_MAP.
  vram_addr=0 in IDLE and PUSH.
- pix_valid never drops and pix_data never changes while pix_ready low (no retraction).
- Latency with pix_ready=1: start at edge 0; RD_MAP/RD_LO/RD_HI in cycles 1-3; first pix_valid in cycle 4. Each subsequent tile costs 3 fetch cycles + 8 push cycles.
- Horizontal map wrap: tile column (scx[7:3]+tile_x) mod 32; a partially used final tile is abandoned at LINE_PIXELS.
- Tile count per line: ceil((LINE_PIXELS+scx[2:0])/8); 20 for scx[2:0]=0, 21 otherwise at 160.

Test Plan:
- scx=0, scy=0, ly=0, map_sel=0, data_sel=1, map byte 0x1800=0x01, tile 1 lo@0x0010=0xF0, hi@0x0011=0xAA, pix_ready=1 -> vram_addr 0x1800,0x0010,0x0011 in cycles 1-3; pixels 3,1,3,1,2,0,2,0 from cycle 4.
- Full line, pix_ready=1, scx[2:0]=0 -> exactly 160 transfers, 20 map reads, done in cycle 221 (1+20*11), busy low with done.
- scx=0x05 -> first tile gives 3 pixels (bits 2..0), 21 map reads starting at 0x1800, last tile truncated after 5 pixels, 160 total.
- data_sel=0, idx=0x80, scy=3, ly=0 -> lo address 0x0806, hi 0x0807; map_sel=1, scx=0xF8 -> map reads 0x1C1F then wrap to 0x1C00.
- Random pix_ready stall pattern -> pix_data stable while stalled, order identical to no-stall run, start pulses during busy ignored.
- reset_n asserted mid-PUSH -> all outputs 0 immediately; new start after release runs a full clean line.
